// File: rtl/bili_arty100t.sv
// Arty A7-100T bring-up top: boots IMAGE_BYTES from SPI flash into a byte RAM, then
// answers UART lookups until a 0xCA,0xCA exit command. Define BILI_UART_ECHO_EN to echo bytes instead.
module bili_arty100t #(
  parameter int         CLOCK_FREQ     = 100_000_000,
  parameter int         BAUD_RATE      = 115200,
  parameter int         SPI_CLK_DIV    = 2,
  parameter int         IMAGE_BYTES    = 64,
  parameter logic [7:0] FLASH_READ_CMD = 8'h03
) (
  input  logic       io_CLK100MHZ,
  input  logic       reset,
  output logic       io_ja_0,
  output logic       io_ja_1,
  output logic       io_ja_2,
  output logic       io_ja_3,
  output logic       io_ja_4,
  output logic       io_ja_5,
  output logic       io_ja_6,
  output logic       io_ja_7,
  input  logic       io_uart_txd_in,
  output logic       io_uart_rxd_out,
  output logic       io_qspi_cs,
  output logic       io_qspi_sck,
  output logic       io_qspi_dq_0,
  input  logic       io_qspi_dq_1,
  output logic       io_qspi_dq_2,
  output logic       io_qspi_dq_3,
  output logic       io_led,
  input  logic [3:0] io_sw,
  input  logic [3:0] io_btn,
  input  logic       io_ck_ioa,
  input  logic       io_ck_rst,
  input  logic       io_eth_col,
  input  logic       io_eth_crs,
  input  logic       io_eth_rx_dv,
  input  logic       io_eth_rxerr,
  input  logic [3:0] io_eth_rxd
);
  localparam int BAUD_DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int SW = (SPI_CLK_DIV > 1) ? $clog2(SPI_CLK_DIV) : 1;
  localparam int AW = (IMAGE_BYTES > 1) ? $clog2(IMAGE_BYTES) : 1;
  localparam logic [SW-1:0] SPI_LAST  = SW'(SPI_CLK_DIV - 1);
  localparam logic [AW-1:0] LAST_BYTE = AW'(IMAGE_BYTES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {BOOT_CMD, BOOT_DATA, SERVE, EXITED} state_t;
  state_t state, state_next;
  logic [7:0] tohost;

  // ---------------- SPI flash boot ----------------
  logic          cs_q, sck_q, spi_done;
  logic [SW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [AW-1:0] byte_idx;
  logic [31:0]   cmd_shift;
  logic [6:0]    miso_shift;
  logic          booting, spi_tick, sck_rise, sck_fall, ram_we;
  logic [7:0]    ram_wdata;

  assign booting   = (state == BOOT_CMD) || (state == BOOT_DATA);
  assign spi_tick  = booting && !cs_q && !spi_done && (div_cnt == SPI_LAST);
  assign sck_rise  = spi_tick && !sck_q;
  assign sck_fall  = spi_tick && sck_q;
  assign ram_wdata = {miso_shift, io_qspi_dq_1};
  assign ram_we    = sck_rise && (state == BOOT_DATA) && (bit_cnt[2:0] == 3'd7);

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge io_CLK100MHZ or posedge reset) begin
    if (reset) begin
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      spi_done   <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      cmd_shift  <= '0;
      miso_shift <= '0;
    end else if (booting) begin
      if (spi_done) begin
        cs_q <= 1'b1;
      end else if (cs_q) begin
        cs_q      <= 1'b0;
        cmd_shift <= {FLASH_READ_CMD, 24'h000000};
        div_cnt   <= '0;
      end else if (!spi_tick) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        sck_q   <= !sck_q;
        if (sck_rise) begin
          miso_shift <= ram_wdata[6:0];
        end else begin
          // MOSI (cmd_shift[31]) only moves on the falling SCK edge
          bit_cnt   <= bit_cnt + 1'b1;
          cmd_shift <= {cmd_shift[30:0], 1'b0};
          if (state == BOOT_DATA && bit_cnt[2:0] == 3'd7) begin
            if (byte_idx == LAST_BYTE) spi_done <= 1'b1;
            else                       byte_idx <= byte_idx + 1'b1;
          end
        end
      end
    end
  end

  logic [7:0] ram [IMAGE_BYTES];

  // NOTE: the image RAM is deliberately not reset; boot rewrites every entry before SERVE reads it.
  always_ff @(posedge io_CLK100MHZ) begin
    if (ram_we) ram[byte_idx] <= ram_wdata;
  end

  // ---------------- UART receiver ----------------
  logic          rx_meta, rx_sync, rx_prev, rx_busy;
  logic [BW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_data;
  logic          rx_stop, rx_valid, rx_ferr;

  assign rx_stop  = rx_busy && (rx_cnt == '0) && (rx_bit == 4'd9);
  assign rx_valid = rx_stop && rx_sync;
  assign rx_ferr  = rx_stop && !rx_sync;

  always_ff @(posedge io_CLK100MHZ or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_data <= '0;
    end else begin
      rx_meta <= io_uart_txd_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (!rx_busy) begin
        if (rx_prev && !rx_sync) begin
          rx_busy <= 1'b1;
          rx_cnt  <= HALF_LAST;
          rx_bit  <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= BIT_LAST;
        rx_bit <= rx_bit + 1'b1;
        // a start bit that is high again at half-bit was a glitch
        if ((rx_bit == 4'd0 && rx_sync) || rx_bit == 4'd9) rx_busy <= 1'b0;
        else if (rx_bit != 4'd0)                           rx_data <= {rx_sync, rx_data[7:1]};
      end
    end
  end

  // ---------------- response path and UART transmitter ----------------
  logic [7:0] resp;
`ifdef BILI_UART_ECHO_EN
  assign resp = rx_data;
`else
  logic [AW-1:0] lookup_idx;
  assign lookup_idx = AW'({24'd0, rx_data} % IMAGE_BYTES);
  assign resp       = ram[lookup_idx];
`endif

  logic          pend_full, last_ca, exit_armed, tx_busy, txd_q;
  logic [7:0]    pend_data, tx_byte;
  logic [BW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;
  logic          accept, tx_start, tx_done;

  assign accept   = (state == SERVE) && !exit_armed && rx_valid && !(pend_full && tx_busy);
  assign tx_start = !tx_busy && (pend_full || accept);
  assign tx_byte  = pend_full ? pend_data : resp;
  assign tx_done  = tx_busy && (tx_cnt == '0) && (tx_bit == 4'd9);

  always_ff @(posedge io_CLK100MHZ or posedge reset) begin
    if (reset) begin
      pend_full  <= 1'b0;
      pend_data  <= '0;
      last_ca    <= 1'b0;
      exit_armed <= 1'b0;
    end else begin
      if (accept && (tx_busy || pend_full)) begin
        pend_full <= 1'b1;
        pend_data <= resp;
      end else if (tx_start) begin
        pend_full <= 1'b0;
      end
      if (accept) begin
        last_ca <= (rx_data == 8'hCA);
        if (last_ca && rx_data == 8'hCA) exit_armed <= 1'b1;
      end else if (rx_ferr && state == SERVE) begin
        last_ca <= 1'b0;
      end
    end
  end

  always_ff @(posedge io_CLK100MHZ or posedge reset) begin
    if (reset) begin
      tx_busy  <= 1'b0;
      txd_q    <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy  <= 1'b1;
        txd_q    <= 1'b0;
        tx_shift <= {1'b1, tx_byte};
        tx_cnt   <= BIT_LAST;
        tx_bit   <= '0;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - 1'b1;
    end else if (tx_bit == 4'd9) begin
      tx_busy <= 1'b0;
    end else begin
      txd_q    <= tx_shift[0];
      tx_shift <= {1'b1, tx_shift[8:1]};
      tx_cnt   <= BIT_LAST;
      tx_bit   <= tx_bit + 1'b1;
    end
  end

  // ---------------- top-level FSM ----------------
  always_ff @(posedge io_CLK100MHZ or posedge reset) begin
    if (reset) state <= BOOT_CMD;
    else       state <= state_next;
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_next = state;
    tohost     = 8'h00;
    io_led     = 1'b0;
    case (state)
      BOOT_CMD:  if (sck_fall && bit_cnt == 5'd31) state_next = BOOT_DATA;
      BOOT_DATA: if (spi_done) state_next = SERVE;
      SERVE: begin
        tohost = 8'h02;
        io_led = 1'b1;
        if (exit_armed && tx_done && !pend_full) state_next = EXITED;
      end
      EXITED: begin
        tohost = 8'h01;
        io_led = 1'b1;
      end
      default: state_next = BOOT_CMD;
    endcase
  end

  assign {io_ja_7, io_ja_6, io_ja_5, io_ja_4, io_ja_3, io_ja_2, io_ja_1, io_ja_0} = tohost;
  assign io_uart_rxd_out = txd_q;
  assign io_qspi_cs      = cs_q;
  assign io_qspi_sck     = sck_q;
  assign io_qspi_dq_0    = cmd_shift[31];
  assign io_qspi_dq_2    = 1'b1;
  assign io_qspi_dq_3    = 1'b1;

  logic unused_pins;
  assign unused_pins = ^{io_sw, io_btn, io_ck_ioa, io_ck_rst, io_eth_col, io_eth_crs,
                         io_eth_rx_dv, io_eth_rxerr, io_eth_rxd};
endmodule

// File: tb/tb_bili_arty100t.sv
// Directed bench for bili_arty100t: flash model holding i^0x5A, UART driver and monitor.
// The UART runs at 20 clocks per bit so the whole sequence stays short.
module tb_bili_arty100t;
  localparam int CLOCK_FREQ = 100_000_000;
  localparam int BAUD_RATE  = 5_000_000;
  localparam int DIV        = CLOCK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tohost;
  logic       uart_to_dut = 1'b1;
  logic       uart_from_dut, cs, sck, mosi, wp, hold, led;
  logic       miso = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bili_arty100t #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .io_CLK100MHZ(clk), .reset(reset),
    .io_ja_0(tohost[0]), .io_ja_1(tohost[1]), .io_ja_2(tohost[2]), .io_ja_3(tohost[3]),
    .io_ja_4(tohost[4]), .io_ja_5(tohost[5]), .io_ja_6(tohost[6]), .io_ja_7(tohost[7]),
    .io_uart_txd_in(uart_to_dut), .io_uart_rxd_out(uart_from_dut),
    .io_qspi_cs(cs), .io_qspi_sck(sck), .io_qspi_dq_0(mosi), .io_qspi_dq_1(miso),
    .io_qspi_dq_2(wp), .io_qspi_dq_3(hold), .io_led(led),
    .io_sw(4'h0), .io_btn(4'h0), .io_ck_ioa(1'b0), .io_ck_rst(1'b0),
    .io_eth_col(1'b0), .io_eth_crs(1'b0), .io_eth_rx_dv(1'b0), .io_eth_rxerr(1'b0),
    .io_eth_rxd(4'h0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash model: captures the 32 command bits, then serves byte i = i^0x5A MSB-first.
  int         rise_cnt = 0;
  logic [31:0] cmd_rx = '0;
  logic [7:0]  flash_byte;

  always @(negedge cs) begin
    rise_cnt = 0;
    cmd_rx   = '0;
  end

  always @(posedge sck) begin
    if (!cs) begin
      if (rise_cnt < 32) cmd_rx = {cmd_rx[30:0], mosi};
      rise_cnt++;
    end
  end

  always @(negedge sck) begin
    if (!cs && rise_cnt >= 32) begin
      flash_byte = 8'((rise_cnt - 32) / 8) ^ 8'h5A;
      miso = flash_byte[7 - ((rise_cnt - 32) % 8)];
    end
  end

  // UART monitor on the DUT transmit line.
  logic [7:0] resp_q[$];
  logic [7:0] mon_byte;
  logic       mon_prev;

  initial begin
    mon_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_prev && !uart_from_dut) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          mon_byte[i] = uart_from_dut;
        end
        repeat (DIV) @(negedge clk);
        resp_q.push_back(mon_byte);
      end
      mon_prev = uart_from_dut;
    end
  end

  task automatic uart_send(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_to_dut = frame[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic expect_resp(input string tag, input logic [7:0] exp);
    logic [31:0] got;
    int          waited;
    got    = 32'h100;
    waited = 0;
    while (resp_q.size() == 0 && waited < 40 * DIV) begin
      @(negedge clk);
      waited++;
    end
    if (resp_q.size() != 0) got = {24'd0, resp_q.pop_front()};
    check(tag, got, {24'd0, exp});
  endtask

  typedef struct { logic [7:0] req; logic [7:0] rsp; } vec_t;
  vec_t lookups[5] = '{'{8'h05, 8'h5F}, '{8'h45, 8'h5F}, '{8'h00, 8'h5A},
                       '{8'hFF, 8'h65}, '{8'h3F, 8'h65}};

  int n_low;
  int guard;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_wp_hold", {wp, hold}, 2'b11);
    check("rst_tohost", tohost, 8'h00);
    check("rst_led", led, 0);
    check("rst_txd", uart_from_dut, 1);

    // reset in the middle of a boot
    reset = 1'b0;
    repeat (1000) @(negedge clk);
    check("midboot_cs_low", cs, 0);
    #1 reset = 1'b1;
    #1;
    check("midboot_rst_cs", cs, 1);
    check("midboot_rst_sck", sck, 0);
    check("midboot_rst_tohost", tohost, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // full boot, with a UART byte that finishes long before boot does
    fork
      begin
        n_low = 0;
        guard = 0;
        while (cs && guard < 20) begin
          @(negedge clk);
          guard++;
        end
        while (!cs && n_low < 3000) begin
          @(negedge clk);
          n_low++;
        end
      end
      begin
        repeat (10) @(negedge clk);
        uart_send(8'h05);
      end
    join
    check("boot_len", (n_low >= 2172 && n_low <= 2180) ? 2176 : n_low, 2176);
    check("boot_cmd_bits", cmd_rx, 32'h0300_0000);
    repeat (2) @(negedge clk);
    check("boot_tohost", tohost, 8'h02);
    check("boot_led", led, 1);
    check("boot_sck_idle", sck, 0);
    repeat (3 * DIV) @(negedge clk);
    check("early_rx_ignored", resp_q.size(), 0);

    // broken exit pair
    uart_send(8'hCA);
    uart_send(8'h11);
    uart_send(8'hCA);
    expect_resp("pair_ca1", 8'h50);
    expect_resp("pair_11", 8'h4B);
    expect_resp("pair_ca2", 8'h50);
    repeat (2 * DIV) @(negedge clk);
    check("pair_tohost", tohost, 8'h02);

    // lookups, sent back-to-back so later ones queue behind the transmitter
    foreach (lookups[i]) uart_send(lookups[i].req);
    foreach (lookups[i]) expect_resp($sformatf("lookup_%02h", lookups[i].req), lookups[i].rsp);

    // exit command
    uart_send(8'hCA);
    uart_send(8'hCA);
    expect_resp("exit_ca1", 8'h50);
    expect_resp("exit_ca2", 8'h50);
    check("exit_tohost_before_stop", tohost, 8'h02);
    repeat (DIV / 2 + 3) @(negedge clk);
    check("exit_tohost", tohost, 8'h01);
    uart_send(8'h05);
    repeat (15 * DIV) @(negedge clk);
    check("exited_no_tx", resp_q.size(), 0);
    check("exited_txd_idle", uart_from_dut, 1);
    check("exited_tohost_hold", tohost, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/bili_arty100t.md
# bili_arty100t

Board-level top for the Arty A7-100T bring-up image. After reset it boots a firmware image from the external SPI flash into an internal byte RAM. It then serves single-byte lookup requests over a 115200-baud UART and reports status to the host through the 8-bit `tohost` bus on the JA header. It sits directly under the simulation/FPGA harness and owns all board pins.

## Interface
- `CLOCK_FREQ`, 100_000_000: `io_CLK100MHZ` frequency in Hz.
- `BAUD_RATE`, 115200: UART bit rate; divisor `CLOCK_FREQ/BAUD_RATE` (868).
- `SPI_CLK_DIV`, 2: clock cycles per SCLK half-period.
- `IMAGE_BYTES`, 64: bytes loaded from flash; legal range 1..1024.
- `FLASH_READ_CMD`, 0x03: SPI read opcode.

Ports:
- `io_CLK100MHZ`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `io_ja_0..io_ja_7`  out  1 each  `tohost[7:0]`.
- `io_uart_txd_in`  in  1  UART RX line (host→DUT), idle high.
- `io_uart_rxd_out`  out  1  UART TX line (DUT→host), idle high.
- `io_qspi_cs`  out  1  flash chip select, active low.
- `io_qspi_sck`  out  1  flash SCLK, SPI mode 0.
- `io_qspi_dq_0`  out  1  MOSI.
- `io_qspi_dq_1`  in  1  MISO.
- `io_qspi_dq_2`, `io_qspi_dq_3`  out  1  WP#/HOLD#, driven constant 1.
- `io_led`  out  1  high once boot completes.
- `io_sw[3:0]`, `io_btn[3:0]`, `io_ck_ioa`, `io_ck_rst`, `io_eth_*`  in  various  unused, ignored.

## Operation
- State machine: BOOT_CMD → BOOT_DATA → SERVE → EXITED.
- BOOT_CMD:
  - CS low, then shift 32 bits MSB-first: `FLASH_READ_CMD` followed by 24-bit address 0x000000.
- BOOT_DATA:
  - Shift in `IMAGE_BYTES` bytes MSB-first; byte k is written to RAM[k].
  - After the last byte, CS goes high, `tohost`=0x02, `io_led`=1, then enter SERVE.
- SERVE:
  - Each received UART byte b produces one response byte RAM[b mod IMAGE_BYTES], sent 8N1.
  - Two consecutive received bytes equal to 0xCA form the exit command. The second 0xCA is still answered. `tohost`=0x01 is set the cycle after that response's stop bit ends, then enter EXITED.
- EXITED: RX ignored, TX idle high, `tohost` holds 0x01 until reset.
- RX bytes whose stop bit completes before SERVE are discarded, not answered.
- Response buffering: one pending-response register.
  - A byte arriving while TX is busy and pending is empty is queued.
  - A byte arriving while pending is full is dropped and does not count toward the 0xCA pair.
- RX framing error (stop bit 0): byte discarded; it breaks a 0xCA pair.

## Timing
- Reset values:
  - `tohost`=0x00, `io_led`=0, `io_uart_rxd_out`=1.
  - `io_qspi_cs`=1, `io_qspi_sck`=0, `io_qspi_dq_0`=0, `io_qspi_dq_2/3`=1.
  - State BOOT_CMD; RAM contents undefined.
- CS falls the first cycle after reset deasserts.
- SPI timing:
  - MOSI changes while SCK is low; MISO is sampled on the SCK rising edge.
  - SCK period is 2·`SPI_CLK_DIV` cycles.
  - SCK idles low and returns low before CS rises.
- Boot length: (32+8·`IMAGE_BYTES`)·2·`SPI_CLK_DIV` cycles, ±4 cycles (2176 at defaults).
- UART RX:
  - `io_uart_txd_in` passes through a 2-flop synchronizer.
  - A falling edge starts reception; the start bit is re-checked at half-bit (434 cycles) and the byte aborts if the line is high.
  - Data is sampled every 868 cycles, LSB first.
- UART TX: starts a response within 2 cycles of the RX stop-bit sample; each bit is held 868 cycles.
- Reset asserted mid-boot or mid-transfer: all outputs return to reset values immediately (async), and boot restarts from BOOT_CMD.

## Configuration
- `BILI_UART_ECHO_EN` defined: SERVE responds with the received byte b itself; RAM is not read. Boot, exit detection and `tohost` are unchanged.
- Undefined: image lookup as specified above.

## Test plan
- Boot: flash bytes 0x00..0x3F = i^0x5A → CS low for exactly 2176±4 cycles, first 8 MOSI bits 0x03, then 24 zero bits; `tohost`=0x02 and `io_led`=1 afterwards.
- Lookup: after boot, send 0x05 → TX returns 0x5F; send 0x45 → returns RAM[5]=0x5F (modulo wrap).
- Exit: send 0xCA, 0xCA → two responses RAM[0x0A]=0x50; `tohost`=0x01 after the second stop bit; further RX produces no TX.
- Broken pair: send 0xCA, 0x11, 0xCA → three responses, `tohost` stays 0x02.
- Early RX: byte whose stop bit completes before boot ends → no response, `tohost` 0x02 after boot.
- Reset mid-boot at cycle 1000 → CS high and `tohost`=0x00 immediately; a full boot repeats after release.
